sqrt_result_checker: RTL and testbench
======================================

Name: sqrt_result_checker

Overview:
- Downstream stage of the odd-subtraction square-root datapath.
- On the root engine's completion pulse, captures the 8-bit switch operand and the 4-bit root count.
- Squares the root by iterative addition and produces the signed remainder operand − root² plus a pass/fail flag for floor-sqrt correctness.
- Result is held under a valid/ready handshake for the display/log stage.

Parameters:
- OPERAND_W, 8, operand width (switch input width).
- ROOT_W, 4, root width; must equal OPERAND_W/2.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  one-cycle completion pulse from the root engine.
- operand  in  OPERAND_W  operand that was rooted; sampled with start.
- root  in  ROOT_W  root count from the engine; sampled with start.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- square  out  2*ROOT_W  root × root.
- remainder  out  OPERAND_W+1  two's-complement operand − square.
- root_ok  out  1  1 iff 0 ≤ remainder ≤ 2·root.

Behaviour:
- Reset (async): state=IDLE; busy, res_valid, root_ok = 0; square, remainder = 0; internal acc, cnt and captures = 0.
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- States: IDLE, SQUARE, CHECK, HOLD.
- IDLE:
  - start=1 at edge E0: capture operand and root, acc=0, cnt=root.
  - Next state: SQUARE if root≠0, else CHECK.
  - start=0: stay in IDLE.
- SQUARE: each edge does acc += captured root and cnt -= 1. When cnt reaches 0 (the edge where cnt==1), go to CHECK.
- CHECK, one edge:
  - square = acc.
  - remainder = zero-extended operand − zero-extended acc, in OPERAND_W+1 bits.
  - root_ok = (remainder sign==0) && (remainder ≤ 2·root).
  - res_valid = 1; go to HOLD.
- Latency: res_valid rises after edge E(root+1). Root 0 takes 1 cycle; root 15 takes 16.
- HOLD:
  - Outputs are stable while res_ready=0.
  - Edge with res_ready=1: res_valid=0, go to IDLE.
  - square, remainder and root_ok keep their last values until the next CHECK.
- start is only accepted in IDLE. start while busy=1 is dropped, including start in the same cycle as the HOLD handshake; upstream must re-issue it.
- res_ready outside HOLD is ignored.
- Reset mid-operation (any state): immediate return to reset values; no partial result is emitted.
- All arithmetic is unsigned except the remainder. Max square is 225 and max remainder is 255, so no overflow at default widths.

Optional Feature:
- Macro: SQRT_CHECK_OVERRUN_EN.
- Defined:
  - Extra output overrun (1 bit, reset 0).
  - overrun sets sticky on any start=1 while busy=1.
  - Cleared only by reset.
- Undefined: port absent; dropped starts are silent.

Decomposition:
- Shared package sqrt_pkg:
  - constants OPERAND_W=8 and ROOT_W=4;
  - the checker state enum (IDLE/SQUARE/CHECK/HOLD, 2-bit encoding);
  - the ALU function-code constants, so datapath and checker share one source.
- One natural sub-module, repeat_add_squarer: holds acc and cnt, takes load and step inputs, gives a done output. The checker FSM drives it and does the remainder/compare itself.

Test Plan:
- operand=32, root=5, start pulse → res_valid after 6 edges; square=25, remainder=7, root_ok=1; busy high for cycles 1–6.
- operand=255, root=15 → res_valid after 16 edges; square=225, remainder=30, root_ok=1.
- operand=0, root=0 → res_valid after 1 edge; square=0, remainder=0, root_ok=1.
- Failing roots:
  - operand=36, root=5 → remainder=11, root_ok=0.
  - operand=20, root=5 → remainder=9'h1FB (−5), root_ok=0.
- Backpressure and dropped starts:
  - Hold res_ready=0 for 3 cycles in HOLD → outputs unchanged.
  - Pulse start during SQUARE and during the handshake cycle → both ignored; next IDLE start still works.
  - With SQRT_CHECK_OVERRUN_EN, overrun=1 and stays 1.
- Assert reset during SQUARE with root=9 → busy, res_valid, square, remainder and root_ok are all 0 immediately. A subsequent start with operand=81, root=9 gives remainder=0, root_ok=1 after 10 edges.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the odd-subtraction square-root datapath and its result checker.
package sqrt_pkg;

  localparam int OPERAND_W = 8;
  localparam int ROOT_W    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    CHECK  = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Function codes for the accumulate/count unit.
  localparam logic [1:0] ALU_NOP  = 2'd0;
  localparam logic [1:0] ALU_LOAD = 2'd1;
  localparam logic [1:0] ALU_ACC  = 2'd2;

endpackage

// File: rtl/repeat_add_squarer.sv
// Squares a small root by adding it to an accumulator once per count step.
module repeat_add_squarer #(
  parameter int ROOT_W = sqrt_pkg::ROOT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ROOT_W-1:0]     count,
  input  logic [ROOT_W-1:0]     addend,
  output logic [2*ROOT_W-1:0]   acc,
  output logic                  done
);
  import sqrt_pkg::*;

  logic [ROOT_W-1:0] cnt;
  logic [1:0]        op;

  assign op   = load ? ALU_LOAD : (step ? ALU_ACC : ALU_NOP);
  // Asserted on the step that retires the last addition.
  assign done = (cnt == ROOT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      case (op)
        ALU_LOAD: begin
          acc <= '0;
          cnt <= count;
        end
        ALU_ACC: begin
          acc <= acc + {{ROOT_W{1'b0}}, addend};
          cnt <= cnt - ROOT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sqrt_result_checker.sv
// Verifies a floor-sqrt result: squares the root, forms operand - root^2, flags correctness.
// Optional sticky overrun flag for dropped starts: define SQRT_CHECK_OVERRUN_EN.
module sqrt_result_checker #(
  parameter int OPERAND_W = sqrt_pkg::OPERAND_W,
  parameter int ROOT_W    = sqrt_pkg::ROOT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OPERAND_W-1:0]   operand,
  input  logic [ROOT_W-1:0]      root,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*ROOT_W-1:0]    square,
  output logic [OPERAND_W:0]     remainder,
  output logic                   root_ok
`ifdef SQRT_CHECK_OVERRUN_EN
  ,
  output logic                   overrun
`endif
);
  import sqrt_pkg::*;

  state_e                 state, next_state;
  logic [OPERAND_W-1:0]   operand_q;
  logic [ROOT_W-1:0]      root_q;
  logic                   load, step, sq_done;
  logic [2*ROOT_W-1:0]    acc;
  logic [OPERAND_W:0]     diff, two_root;

  repeat_add_squarer #(.ROOT_W(ROOT_W)) u_squarer (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .count  (root),
    .addend (root_q),
    .acc    (acc),
    .done   (sq_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: if (start) begin
        load       = 1'b1;
        next_state = (root != '0) ? SQUARE : CHECK;
      end
      SQUARE: begin
        step = 1'b1;
        if (sq_done) next_state = CHECK;
      end
      CHECK:   next_state = HOLD;
      HOLD:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD);

  // NOTE: capture registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      operand_q <= '0;
      root_q    <= '0;
    end else if (load) begin
      operand_q <= operand;
      root_q    <= root;
    end
  end

  // Remainder is formed one bit wider so a too-large root shows up as a negative value.
  assign diff     = {1'b0, operand_q} - {{(OPERAND_W + 1 - 2*ROOT_W){1'b0}}, acc};
  assign two_root = {{(OPERAND_W - ROOT_W){1'b0}}, root_q, 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      square    <= '0;
      remainder <= '0;
      root_ok   <= 1'b0;
    end else if (state == CHECK) begin
      square    <= acc;
      remainder <= diff;
      root_ok   <= !diff[OPERAND_W] && (diff <= two_root);
    end
  end

`ifdef SQRT_CHECK_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              overrun <= 1'b0;
    else if (start && busy) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sqrt_result_checker.sv
// Directed-vector bench for sqrt_result_checker with a queue-based scoreboard.
module tb_sqrt_result_checker;

  typedef struct packed {
    logic [7:0] sq;
    logic [8:0] rem;
    logic       ok;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] operand;
  logic [3:0] root;
  logic       busy;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] square;
  logic [8:0] remainder;
  logic       root_ok;
`ifdef SQRT_CHECK_OVERRUN_EN
  logic       overrun;
`endif

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  bit   prev_valid = 1'b0;

  always #5 clk = ~clk;

  sqrt_result_checker dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .operand   (operand),
    .root      (root),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .square    (square),
    .remainder (remainder),
    .root_ok   (root_ok)
`ifdef SQRT_CHECK_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard comparison per rising res_valid.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_square", 32'(square), 32'(e.sq));
          check("sb_remainder", 32'(remainder), 32'(e.rem));
          check("sb_root_ok", 32'(root_ok), 32'(e.ok));
        end
      end
      prev_valid = res_valid;
    end
  end

  task automatic run_vec(input logic [7:0] op, input logic [3:0] rt,
                         input logic [7:0] sq, input logic [8:0] rem, input logic ok,
                         input int hold, input bit drop_mid, input bit drop_hs);
    exp_t e;
    e = '{sq: sq, rem: rem, ok: ok};
    exp_q.push_back(e);
    operand = op; root = rt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; operand = 8'hAA; root = 4'h3;
    check("busy_after_start", 32'(busy), 32'd1);
    if (drop_mid) begin
      start = 1'b1; operand = 8'h00; root = 4'h1;
    end
    for (int k = 0; k < int'(rt); k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("valid_not_early", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("valid_at_latency", 32'(res_valid), 32'd1);
    check("busy_in_hold", 32'(busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_square", 32'(square), 32'(sq));
      check("hold_remainder", 32'(remainder), 32'(rem));
      check("hold_root_ok", 32'(root_ok), 32'(ok));
    end
    res_ready = 1'b1;
    if (drop_hs) begin
      start = 1'b1; operand = 8'h10; root = 4'h4;
    end
    @(posedge clk); #1;
    res_ready = 1'b0; start = 1'b0;
    check("valid_after_accept", 32'(res_valid), 32'd0);
    check("idle_after_accept", 32'(busy), 32'd0);
    check("square_kept", 32'(square), 32'(sq));
    check("remainder_kept", 32'(remainder), 32'(rem));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operand = '0; root = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_square", 32'(square), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_root_ok", 32'(root_ok), 32'd0);
`ifdef SQRT_CHECK_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 32'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // op, root, square, remainder, ok, hold cycles, drop mid, drop at handshake
    run_vec(8'd32,  4'd5,  8'd25,  9'd7,     1'b1, 0, 1'b0, 1'b0);
    run_vec(8'd255, 4'd15, 8'd225, 9'd30,    1'b1, 0, 1'b0, 1'b0);
    run_vec(8'd0,   4'd0,  8'd0,   9'd0,     1'b1, 0, 1'b0, 1'b0);
    run_vec(8'd36,  4'd5,  8'd25,  9'd11,    1'b0, 0, 1'b0, 1'b0);
    run_vec(8'd20,  4'd5,  8'd25,  9'h1FB,   1'b0, 3, 1'b0, 1'b0);
    run_vec(8'd99,  4'd9,  8'd81,  9'd18,    1'b1, 0, 1'b0, 1'b0);
    run_vec(8'd3,   4'd1,  8'd1,   9'd2,     1'b1, 0, 1'b0, 1'b0);
`ifdef SQRT_CHECK_OVERRUN_EN
    check("overrun_still_clear", 32'(overrun), 32'd0);
`endif
    run_vec(8'd50,  4'd7,  8'd49,  9'd1,     1'b1, 1, 1'b1, 1'b1);
`ifdef SQRT_CHECK_OVERRUN_EN
    check("overrun_set", 32'(overrun), 32'd1);
`endif
    run_vec(8'd17,  4'd4,  8'd16,  9'd1,     1'b1, 0, 1'b0, 1'b0);
`ifdef SQRT_CHECK_OVERRUN_EN
    check("overrun_sticky", 32'(overrun), 32'd1);
`endif

    // Abort mid-squaring: nothing pushed, nothing may come out.
    operand = 8'd81; root = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_square", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_square", 32'(square), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_root_ok", 32'(root_ok), 32'd0);
`ifdef SQRT_CHECK_OVERRUN_EN
    check("abort_overrun", 32'(overrun), 32'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_vec(8'd81,  4'd9,  8'd81,  9'd0,     1'b1, 0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
